// File: rtl/jbi_min_rq_mq_pkg.sv
// jbi_min_rq_mq_pkg: shared JBI request-queue constants and helpers.
package jbi_min_rq_mq_pkg;
    localparam int JBI_RQ_NUM_CH = 4;
    localparam int JBI_RQ_ADDR_W = 4;
    localparam int JBI_RQ_FULL_MARGIN = 5;
    // Keeps channel-select fields at least one bit wide for single-channel builds.
    function automatic int ch_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/jbi_min_rq_mq_ctl_if.sv
// jbi_min_rq_mq_ctl_if: push/pop request side and RAM strobe side of the multi-queue controller.
interface jbi_min_rq_mq_ctl_if
    import jbi_min_rq_mq_pkg::*;
#(
    parameter int NUM_CH = JBI_RQ_NUM_CH,
    parameter int ADDR_W = JBI_RQ_ADDR_W
);
    localparam int CH_W = ch_w(NUM_CH);
    logic push;
    logic [CH_W-1:0] push_ch;
    logic pop;
    logic [CH_W-1:0] pop_ch;
    logic err_clr;
    logic wr_en;
    logic [CH_W+ADDR_W-1:0] waddr;
    logic rd_en;
    logic [CH_W+ADDR_W-1:0] raddr;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] ovf_err;
    logic [NUM_CH-1:0] udf_err;
    modport master (
        output push, push_ch, pop, pop_ch, err_clr,
        input wr_en, waddr, rd_en, raddr, full, empty, ovf_err, udf_err
    );
    modport slave (
        input push, push_ch, pop, pop_ch, err_clr,
        output wr_en, waddr, rd_en, raddr, full, empty, ovf_err, udf_err
    );
endinterface

// File: rtl/jbi_min_rq_mq_ptr.sv
// jbi_min_rq_mq_ptr: one channel's wrap-bit pointer pair with empty, physical-full and registered almost-full.
module jbi_min_rq_mq_ptr #(
    parameter int ADDR_W = 4,
    parameter int FULL_MARGIN = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_sel,
    input  logic              pop_sel,
    output logic              do_push,
    output logic              do_pop,
    output logic              ovf,
    output logic              udf,
    output logic [ADDR_W-1:0] wlo,
    output logic [ADDR_W-1:0] rlo,
    output logic              empty,
    output logic              full
);
    logic [ADDR_W:0] wptr, rptr, nwptr;
    logic [ADDR_W-1:0] gap;
    logic pfull;
    assign empty = wptr == rptr;
    assign pfull = wptr[ADDR_W] != rptr[ADDR_W] && wptr[ADDR_W-1:0] == rptr[ADDR_W-1:0];
    assign do_push = push_sel && !pfull;
    assign do_pop = pop_sel && !empty;
    assign ovf = push_sel && pfull;
    assign udf = pop_sel && empty;
    assign wlo = wptr[ADDR_W-1:0];
    assign rlo = rptr[ADDR_W-1:0];
    assign nwptr = wptr + (ADDR_W+1)'(do_push);
    // Free-entry count against the post-push write pointer; ignoring this cycle's pop keeps it pessimistic.
    assign gap = rptr[ADDR_W-1:0] - nwptr[ADDR_W-1:0];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
            full <= 1'b0;
        end else begin
            wptr <= nwptr;
            rptr <= rptr + (ADDR_W+1)'(do_pop);
            full <= gap < ADDR_W'(FULL_MARGIN) && nwptr != rptr;
        end
    end
endmodule

// File: rtl/jbi_min_rq_mq_ctl.sv
// jbi_min_rq_mq_ctl: NUM_CH queues sharing one RAM; sticky error flags enabled by JBI_MIN_RQ_MQ_ERR_CHK_EN.
module jbi_min_rq_mq_ctl
    import jbi_min_rq_mq_pkg::*;
#(
    parameter int NUM_CH = JBI_RQ_NUM_CH,
    parameter int ADDR_W = JBI_RQ_ADDR_W,
    parameter int FULL_MARGIN = JBI_RQ_FULL_MARGIN
) (
    input logic clk,
    input logic rst,
    jbi_min_rq_mq_ctl_if.slave bus
);
    localparam int CH_W = ch_w(NUM_CH);
    logic [NUM_CH-1:0] push_sel, pop_sel, do_push, do_pop, ovf_set, udf_set, empty, full;
    logic [NUM_CH-1:0][ADDR_W-1:0] wlo, rlo;
    logic [ADDR_W-1:0] waddr_lo, raddr_lo;
    genvar c;
    for (c = 0; c < NUM_CH; c++) begin : g_ch
        // Out-of-range channel numbers match no instance, so they never strobe the RAM.
        assign push_sel[c] = bus.push && !rst && bus.push_ch == CH_W'(c);
        assign pop_sel[c] = bus.pop && !rst && bus.pop_ch == CH_W'(c);
        jbi_min_rq_mq_ptr #(
            .ADDR_W(ADDR_W),
            .FULL_MARGIN(FULL_MARGIN)
        ) u_ptr (
            .clk(clk),
            .rst(rst),
            .push_sel(push_sel[c]),
            .pop_sel(pop_sel[c]),
            .do_push(do_push[c]),
            .do_pop(do_pop[c]),
            .ovf(ovf_set[c]),
            .udf(udf_set[c]),
            .wlo(wlo[c]),
            .rlo(rlo[c]),
            .empty(empty[c]),
            .full(full[c])
        );
    end
    always_comb begin
        waddr_lo = '0;
        raddr_lo = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            waddr_lo = bus.push_ch == CH_W'(i) ? wlo[i] : waddr_lo;
            raddr_lo = bus.pop_ch == CH_W'(i) ? rlo[i] : raddr_lo;
        end
    end
    assign bus.wr_en = |do_push;
    assign bus.rd_en = |do_pop;
    assign bus.waddr = {bus.push_ch, waddr_lo};
    assign bus.raddr = {bus.pop_ch, raddr_lo};
    assign bus.empty = empty;
    assign bus.full = full;
`ifdef JBI_MIN_RQ_MQ_ERR_CHK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.ovf_err <= '0;
            bus.udf_err <= '0;
        end else if (bus.err_clr) begin
            bus.ovf_err <= '0;
            bus.udf_err <= '0;
        end else begin
            bus.ovf_err <= bus.ovf_err | ovf_set;
            bus.udf_err <= bus.udf_err | udf_set;
        end
    end
`else
    logic unused_err;
    assign unused_err = ^{bus.err_clr, ovf_set, udf_set};
    assign bus.ovf_err = '0;
    assign bus.udf_err = '0;
`endif
endmodule
